mem_arbiter: RTL and testbench

- Two-master arbiter in front of the unified memory/peripheral port (address, write_data, read_data, we, re).
- Shares the port between the CPU load/store unit (master 0) and a DMA/streaming engine (master 1).
- Round-robin or fixed priority, with a bounded bus lock for atomic sequences.
- Routes read data back to the master that issued the read, after a fixed read latency.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the unified memory/peripheral port.
// Master 0 is the CPU load/store unit and master 1 is the DMA/streaming engine.
// It supports round-robin or fixed-priority arbitration and a bounded bus lock.
// Read data is routed back to the master that issued the read.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mN_req/we/lock/addr/wdata  master N request channel
//   mN_gnt                     access accepted this cycle (combinational)
//   mN_rvalid/rdata            read return, READ_LATENCY cycles after accept
//   mem_address/write_data/we/re  shared memory port (combinational)
//   mem_read_data              memory read data
module mem_arbiter #(
    parameter int unsigned FIXED_PRIO   = 0,
    parameter int unsigned MAX_LOCK     = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned CW  = 8;
    localparam int unsigned LAT = READ_LATENCY;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_e;

    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    state_e          state_q, state_d;
    logic            last_q, last_d;     // id of the last granted master
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            own, own_lock;
    logic            gnt0, gnt1;
    tag_t            push;
    tag_t            tag_q [LAT];
    tag_t            tag_out;

    // Grant decision from registered state and current requests
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state_q)
            ST_LOCK0: gnt0 = m0_req;
            ST_LOCK1: gnt1 = m1_req;
            default: begin
                if (m0_req && m1_req) begin
                    if ((FIXED_PRIO != 0) || last_q) gnt0 = 1'b1;
                    else                             gnt1 = 1'b1;
                end else begin
                    gnt0 = m0_req;
                    gnt1 = m1_req;
                end
            end
        endcase
        // Grants are suppressed while reset is held so the port is quiet immediately
        if (!rst_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // Memory port drive from the granted master
    always_comb begin
        mem_address    = gnt0 ? m0_addr  : (gnt1 ? m1_addr  : 32'd0);
        mem_write_data = gnt0 ? m0_wdata : (gnt1 ? m1_wdata : 32'd0);
        mem_we         = (gnt0 & m0_we)  | (gnt1 & m1_we);
        mem_re         = (gnt0 & ~m0_we) | (gnt1 & ~m1_we);
    end

    // Next-state logic: arbitration history and lock counter
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        own      = (state_q == ST_LOCK1);
        own_lock = own ? m1_lock : m0_lock;
        cnt_inc  = (cnt_q >= CW'(MAX_LOCK)) ? cnt_q : cnt_q + CW'(1);
        unique case (state_q)
            ST_LOCK0, ST_LOCK1: begin
                cnt_d = cnt_inc;
                if (!own_lock || (cnt_inc >= CW'(MAX_LOCK))) begin
                    state_d = ST_IDLE;
                    last_d  = own;
                    cnt_d   = '0;
                end
            end
            default: begin
                // A one-cycle lock budget is used up by the grant itself
                if (gnt0) begin
                    last_d = 1'b0;
                    if (m0_lock && (MAX_LOCK > 1)) begin
                        state_d = ST_LOCK0;
                        cnt_d   = CW'(1);
                    end
                end else if (gnt1) begin
                    last_d = 1'b1;
                    if (m1_lock && (MAX_LOCK > 1)) begin
                        state_d = ST_LOCK1;
                        cnt_d   = CW'(1);
                    end
                end
            end
        endcase
    end

    assign push.vld = (gnt0 & ~m0_we) | (gnt1 & ~m1_we);
    assign push.id  = gnt1;

    // State registers and read-tag pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            for (int i = 0; i < int'(LAT); i++) tag_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            tag_q[0] <= push;
            for (int i = 1; i < int'(LAT); i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Read return routed by the tag leaving the pipeline
    assign tag_out   = tag_q[LAT-1];
    assign m0_rvalid = tag_out.vld & ~tag_out.id;
    assign m1_rvalid = tag_out.vld &  tag_out.id;
    assign m0_rdata  = m0_rvalid ? mem_read_data : 32'd0;
    assign m1_rdata  = m1_rvalid ? mem_read_data : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances share one stimulus.
//   u[0]: round-robin, MAX_LOCK=4,  READ_LATENCY=1
//   u[1]: fixed prio,  MAX_LOCK=16, READ_LATENCY=1
//   u[2]: round-robin, MAX_LOCK=16, READ_LATENCY=3
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_read_data;

    logic        m0_gnt [3];
    logic        m1_gnt [3];
    logic        m0_rvalid [3];
    logic        m1_rvalid [3];
    logic [31:0] m0_rdata [3];
    logic [31:0] m1_rdata [3];
    logic [31:0] mem_address [3];
    logic [31:0] mem_write_data [3];
    logic        mem_we [3];
    logic        mem_re [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.FIXED_PRIO(0), .MAX_LOCK(4), .READ_LATENCY(1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt[0]), .m0_rvalid(m0_rvalid[0]), .m0_rdata(m0_rdata[0]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt[0]), .m1_rvalid(m1_rvalid[0]), .m1_rdata(m1_rdata[0]),
        .mem_address(mem_address[0]), .mem_write_data(mem_write_data[0]),
        .mem_we(mem_we[0]), .mem_re(mem_re[0]), .mem_read_data(mem_read_data));

    mem_arbiter #(.FIXED_PRIO(1), .MAX_LOCK(16), .READ_LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt[1]), .m0_rvalid(m0_rvalid[1]), .m0_rdata(m0_rdata[1]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt[1]), .m1_rvalid(m1_rvalid[1]), .m1_rdata(m1_rdata[1]),
        .mem_address(mem_address[1]), .mem_write_data(mem_write_data[1]),
        .mem_we(mem_we[1]), .mem_re(mem_re[1]), .mem_read_data(mem_read_data));

    mem_arbiter #(.FIXED_PRIO(0), .MAX_LOCK(16), .READ_LATENCY(3)) u2 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt[2]), .m0_rvalid(m0_rvalid[2]), .m0_rdata(m0_rdata[2]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt[2]), .m1_rvalid(m1_rvalid[2]), .m1_rdata(m1_rdata[2]),
        .mem_address(mem_address[2]), .mem_write_data(mem_write_data[2]),
        .mem_we(mem_we[2]), .mem_re(mem_re[2]), .mem_read_data(mem_read_data));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        mem_read_data = '0;
        rst_n = 1'b0;

        // Reset: outputs quiet even with a request pending
        m0_req = 1'b1; m0_addr = 32'h4000;
        #2;
        check("rst_m0_gnt",   32'(m0_gnt[0]), 32'd0);
        check("rst_mem_re",   32'(mem_re[0]), 32'd0);
        check("rst_mem_addr", mem_address[0], 32'd0);
        check("rst_m0_rvalid", 32'(m0_rvalid[0]), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single m0 read 0x4000, latency 1
        mem_read_data = 32'hAAAA_0000;
        #1;
        check("t1_m0_gnt",   32'(m0_gnt[0]), 32'd1);
        check("t1_m1_gnt",   32'(m1_gnt[0]), 32'd0);
        check("t1_mem_re",   32'(mem_re[0]), 32'd1);
        check("t1_mem_addr", mem_address[0], 32'h4000);
        tick();
        m0_req = 1'b0;
        mem_read_data = 32'h1234_5678;
        #1;
        check("t1_m0_rvalid", 32'(m0_rvalid[0]), 32'd1);
        check("t1_m0_rdata",  m0_rdata[0], 32'h1234_5678);
        check("t1_m1_rvalid", 32'(m1_rvalid[0]), 32'd0);
        check("t1_m1_rdata",  m1_rdata[0], 32'd0);
        tick();
        check("t1_rvalid_drop", 32'(m0_rvalid[0]), 32'd0);
        check("t1_rdata_zero",  m0_rdata[0], 32'd0);

        // Round-robin contention: m0,m1,m0,... with returns one cycle later
        do_reset();
        for (int c = 0; c < 6; c++) begin
            m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1000;
            m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h2000;
            mem_read_data = 32'hC000_0000 + 32'(c);
            #1;
            check("rr_m0_gnt", 32'(m0_gnt[0]), 32'((c % 2) == 0));
            check("rr_m1_gnt", 32'(m1_gnt[0]), 32'((c % 2) == 1));
            check("rr_addr", mem_address[0], ((c % 2) == 0) ? 32'h1000 : 32'h2000);
            if (c > 0) begin
                check("rr_m0_rvalid", 32'(m0_rvalid[0]), 32'((c % 2) == 1));
                check("rr_m1_rvalid", 32'(m1_rvalid[0]), 32'((c % 2) == 0));
                check("rr_m0_rdata", m0_rdata[0], ((c % 2) == 1) ? 32'hC000_0000 + 32'(c) : 32'd0);
                check("rr_m1_rdata", m1_rdata[0], ((c % 2) == 0) ? 32'hC000_0000 + 32'(c) : 32'd0);
            end
            tick();
        end
        idle_inputs();
        mem_read_data = 32'hC000_0006;
        #1;
        check("rr_last_m1_rvalid", 32'(m1_rvalid[0]), 32'd1);
        check("rr_last_m1_rdata",  m1_rdata[0], 32'hC000_0006);
        check("rr_last_m0_rvalid", 32'(m0_rvalid[0]), 32'd0);

        // Fixed priority: m0 always wins until it drops its request
        do_reset();
        for (int c = 0; c < 4; c++) begin
            m0_req = 1'b1; m0_addr = 32'h1000;
            m1_req = 1'b1; m1_addr = 32'h2000;
            #1;
            check("fp_m0_gnt", 32'(m0_gnt[1]), 32'd1);
            check("fp_m1_gnt", 32'(m1_gnt[1]), 32'd0);
            tick();
        end
        m0_req = 1'b0;
        #1;
        check("fp_m1_gnt_after", 32'(m1_gnt[1]), 32'd1);
        check("fp_m0_gnt_after", 32'(m0_gnt[1]), 32'd0);
        tick();

        // m1 locked write burst on u2 blocks m0 for 5 cycles
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0;
        #1;
        check("lk_pre_m0_gnt", 32'(m0_gnt[2]), 32'd1);
        tick();
        for (int c = 0; c < 5; c++) begin
            m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h3000;
            m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1;
            m1_addr = 32'h4010; m1_wdata = 32'hDEAD_BEEF;
            #1;
            check("lk_m0_gnt", 32'(m0_gnt[2]), 32'd0);
            check("lk_m1_gnt", 32'(m1_gnt[2]), 32'd1);
            check("lk_mem_we", 32'(mem_we[2]), 32'd1);
            check("lk_mem_addr", mem_address[2], 32'h4010);
            check("lk_mem_wdata", mem_write_data[2], 32'hDEAD_BEEF);
            tick();
        end
        m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0;
        #1;
        check("lk_drop_m0_gnt", 32'(m0_gnt[2]), 32'd0);
        tick();
        check("lk_after_m0_gnt", 32'(m0_gnt[2]), 32'd1);
        check("lk_after_mem_re", 32'(mem_re[2]), 32'd1);
        check("lk_after_addr", mem_address[2], 32'h3000);
        tick();

        // m0 lock bounded by MAX_LOCK=4 on u0
        do_reset();
        for (int c = 0; c < 5; c++) begin
            m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b1; m0_addr = 32'h5000;
            m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h6000;
            #1;
            check("ml_m0_gnt", 32'(m0_gnt[0]), 32'(c < 4));
            check("ml_m1_gnt", 32'(m1_gnt[0]), 32'(c == 4));
            tick();
        end
        // Lock without request is ignored
        do_reset();
        m0_req = 1'b0; m0_lock = 1'b1;
        m1_req = 1'b1; m1_we = 1'b1;
        #1;
        check("nolock_m1_gnt", 32'(m1_gnt[0]), 32'd1);
        tick();
        m1_req = 1'b0;
        m0_req = 1'b1; m0_lock = 1'b0;
        #1;
        check("nolock_m0_gnt", 32'(m0_gnt[0]), 32'd1);
        tick();

        // Reset with reads in flight on u2 (latency 3)
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h7000;
        #1;
        check("rf_m0_gnt", 32'(m0_gnt[2]), 32'd1);
        tick();
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h7004;
        #1;
        check("rf_m1_gnt", 32'(m1_gnt[2]), 32'd1);
        tick();
        m1_req = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h7008;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rf_rst_m0_gnt", 32'(m0_gnt[2]), 32'd0);
        check("rf_rst_mem_re", 32'(mem_re[2]), 32'd0);
        check("rf_rst_addr", mem_address[2], 32'd0);
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rf_no_m0_rvalid", 32'(m0_rvalid[2]), 32'd0);
            check("rf_no_m1_rvalid", 32'(m1_rvalid[2]), 32'd0);
        end
        m0_req = 1'b1; m0_addr = 32'h7010;
        #1;
        check("rf_new_m0_gnt", 32'(m0_gnt[2]), 32'd1);
        tick();
        m0_req = 1'b0;
        tick();
        check("rf_mid_rvalid", 32'(m0_rvalid[2]), 32'd0);
        tick();
        mem_read_data = 32'hBEEF_0003;
        #1;
        check("rf_new_m0_rvalid", 32'(m0_rvalid[2]), 32'd1);
        check("rf_new_m0_rdata", m0_rdata[2], 32'hBEEF_0003);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
